regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the register file's single write port (RegWrite/RD/WriteData) between two writeback sources:
//  A = in-order pipeline writeback (ALU/load), B = long-latency unit (mul/div).
//  Fixed priority to A with an anti-starvation counter for B; registered write outputs; x0 writes suppressed.
//  Keeps a per-register busy scoreboard for B-issued ops so hazard logic can stall dependent readers.
// PARAMETERS
//  XLEN          64  data width of register file write data
//  NREG          32  number of architectural registers (RD width = clog2(NREG) = 5)
//  STARVE_LIMIT   4  consecutive cycles B may lose to A before B is forced to win (>=1)
// PORTS
//  clk            in   1     clock; all state updates on posedge
//  reset          in   1     synchronous, active-high reset
//  a_valid        in   1     source A has a writeback pending
//  a_rd           in   5     A destination register
//  a_data         in   XLEN  A write data
//  a_ready        out  1     A writeback accepted this cycle
//  b_valid        in   1     source B has a writeback pending
//  b_rd           in   5     B destination register
//  b_data         in   XLEN  B write data
//  b_ready        out  1     B writeback accepted this cycle
//  b_issue_valid  in   1     an op destined for B is issued this cycle
//  b_issue_rd     in   5     destination register of that issued op
//  RegWrite       out  1     write enable to register file (registered)
//  RD             out  5     write address to register file (registered)
//  WriteData      out  XLEN  write data to register file (registered)
//  busy_mask      out  NREG  bit r = 1: register r has an outstanding B write
// BEHAVIOUR
//  Reset (reset=1 at posedge): RegWrite=0, RD=0, WriteData=0, busy_mask=0, starve_cnt=0.
//   a_ready=b_ready=0 combinationally while reset=1; any in-flight request is not accepted and must be re-presented.
//  Grant (combinational): starve_sat = (starve_cnt == STARVE_LIMIT).
//   grant_b = b_valid & (~a_valid | starve_sat); grant_a = a_valid & ~grant_b.
//   a_ready = grant_a & ~reset; b_ready = grant_b & ~reset. Handshake completes when valid & ready in the same cycle.
//   Sources hold rd/data stable while valid=1 and ready=0; valid may not drop before acceptance.
//  Starve counter (width clog2(STARVE_LIMIT+1)): +1 when b_valid & grant_a; 0 when grant_b or ~b_valid; saturates at STARVE_LIMIT.
//  Write port: at posedge where a handshake completes with rd != 0: RegWrite<=1, RD<=rd, WriteData<=data for exactly one cycle.
//   Register file latches it at the following negedge -> written value readable in the second half of that cycle.
//   Handshake with rd == 0: accepted (ready=1), RegWrite<=0, RD/WriteData hold previous values; x0 never written.
//   No handshake: RegWrite<=0, RD/WriteData hold. Max one write per cycle; throughput 1 write/cycle.
//  Scoreboard: on posedge, b_issue_valid & b_issue_rd!=0 sets busy[b_issue_rd]; completed B handshake clears busy[b_rd].
//   Same register set and cleared in one cycle: set wins (newer op outstanding). busy[0] is constant 0.
//   Issue to an already-busy register: bit stays 1 (no count; issue logic must not allow two outstanding B ops per rd).
//   A writebacks never touch busy_mask.
//  Reset mid-operation: all state cleared per reset values; no partial write; write registered in the prior cycle has already landed at its negedge.
// STRUCTURE
//  Shared package: XLEN, REG_ADDR_W=5, NREG, REG_X0=5'd0, wb_req_t struct {valid, rd, data}.
//  Sub-module regfile_scoreboard: busy bit vector with set/clear ports and set-wins priority; remainder (grant, starve counter, output regs) inline.
// TESTING
//  A only: a_valid=1,a_rd=5,a_data=0x11 one cycle -> a_ready=1; next cycle RegWrite=1,RD=5,WriteData=0x11; regfile x5=0x11.
//  Contention: a_valid and b_valid held high, STARVE_LIMIT=4 -> A granted 4 cycles, B granted on 5th, counter back to 0.
//  x0 suppression: a_rd=0,a_data=0xFF -> a_ready=1, RegWrite stays 0; x0 reads 0.
//  Scoreboard: issue rd=7 -> busy_mask[7]=1; B writeback rd=7 -> cleared next cycle; same-cycle issue rd=7 + B wb rd=7 -> bit stays 1.
//  Reset mid-stream: reset=1 while a_valid,b_valid high -> both ready=0; after posedge RegWrite=0, busy_mask=0, starve_cnt=0.
//  Back-to-back: A writes rd=1..4 on consecutive cycles -> RegWrite high 4 consecutive cycles, RD=1,2,3,4 in order.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter.
//  XLEN       : register data width
//  NREG       : number of architectural registers
//  REG_ADDR_W : register index width
//  REG_X0     : index of the hardwired-zero register
//  wb_req_t   : one writeback request {valid, rd, data}
package regfile_wb_arbiter_pkg;

    localparam int XLEN       = 64;
    localparam int NREG       = 32;
    localparam int REG_ADDR_W = $clog2(NREG);

    localparam logic [REG_ADDR_W-1:0] REG_X0 = 5'd0;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard for writebacks owned by the long-latency unit.
//  clk, reset : clock, synchronous active-high reset
//  set_en     : an op targeting set_idx was issued this cycle
//  set_idx    : destination register of the issued op
//  clr_en     : a writeback for clr_idx completed this cycle
//  clr_idx    : destination register of the completed writeback
//  busy       : bit r = 1 while register r has an outstanding write
// A set and a clear of the same register in one cycle leave the bit set,
// because the set belongs to the newer op. Bit 0 never becomes busy.
module regfile_scoreboard
    import regfile_wb_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  set_en,
    input  logic [REG_ADDR_W-1:0] set_idx,
    input  logic                  clr_en,
    input  logic [REG_ADDR_W-1:0] clr_idx,
    output logic [NREG-1:0]       busy
);

    logic [NREG-1:0] busy_r;
    logic [NREG-1:0] busy_next_s;

    // Next-state: clear first, then set, so a same-cycle set overrides the clear.
    always_comb begin
        busy_next_s = busy_r;
        if (clr_en) begin
            busy_next_s[clr_idx] = 1'b0;
        end else begin
            busy_next_s = busy_r;
        end
        if (set_en && (set_idx != REG_X0)) begin
            busy_next_s[set_idx] = 1'b1;
        end else begin
            busy_next_s[REG_X0] = 1'b0;
        end
        busy_next_s[REG_X0] = 1'b0;
    end

    // Busy vector register.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r <= {NREG{1'b0}};
        end else begin
            busy_r <= busy_next_s;
        end
    end

    assign busy = busy_r;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file's single write port between two writeback sources.
//  A (a_*) : in-order pipeline writeback, normally has priority
//  B (b_*) : long-latency unit writeback, wins after STARVE_LIMIT lost cycles
//  b_issue_valid/b_issue_rd : op destined for B issued, marks rd busy
//  RegWrite/RD/WriteData    : registered register-file write port
//  busy_mask                : registers with an outstanding B write
// Writes to x0 are accepted but never reach the write port.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  a_valid,
    input  logic [REG_ADDR_W-1:0] a_rd,
    input  logic [XLEN-1:0]       a_data,
    output logic                  a_ready,
    input  logic                  b_valid,
    input  logic [REG_ADDR_W-1:0] b_rd,
    input  logic [XLEN-1:0]       b_data,
    output logic                  b_ready,
    input  logic                  b_issue_valid,
    input  logic [REG_ADDR_W-1:0] b_issue_rd,
    output logic                  RegWrite,
    output logic [REG_ADDR_W-1:0] RD,
    output logic [XLEN-1:0]       WriteData,
    output logic [NREG-1:0]       busy_mask
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_cnt_r;
    logic             starve_sat_s;
    logic             grant_a_s;
    logic             grant_b_s;
    logic             hs_s;
    wb_req_t          a_req_s;
    wb_req_t          b_req_s;
    wb_req_t          sel_req_s;

    assign a_req_s = '{valid: a_valid, rd: a_rd, data: a_data};
    assign b_req_s = '{valid: b_valid, rd: b_rd, data: b_data};

    // B wins when A is idle or B has already lost STARVE_LIMIT times in a row.
    assign starve_sat_s = (starve_cnt_r == CNT_W'(STARVE_LIMIT));
    assign grant_b_s    = b_valid & (~a_valid | starve_sat_s);
    assign grant_a_s    = a_valid & ~grant_b_s;

    assign a_ready = grant_a_s & ~reset;
    assign b_ready = grant_b_s & ~reset;

    // Grants are exclusive, so the granted request alone drives the write port.
    always_comb begin
        sel_req_s = a_req_s;
        if (grant_b_s) begin
            sel_req_s = b_req_s;
        end else begin
            sel_req_s = a_req_s;
        end
    end

    assign hs_s = sel_req_s.valid & (a_ready | b_ready);

    // Consecutive cycles B has been waiting while A was granted.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end else if (grant_b_s || !b_valid) begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end else if (grant_a_s && !starve_sat_s) begin
            starve_cnt_r <= starve_cnt_r + CNT_W'(1'b1);
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

    // Registered write port; RD/WriteData hold when no write is issued.
    always_ff @(posedge clk) begin
        if (reset) begin
            RegWrite  <= 1'b0;
            RD        <= {REG_ADDR_W{1'b0}};
            WriteData <= {XLEN{1'b0}};
        end else if (hs_s && (sel_req_s.rd != REG_X0)) begin
            RegWrite  <= 1'b1;
            RD        <= sel_req_s.rd;
            WriteData <= sel_req_s.data;
        end else begin
            RegWrite  <= 1'b0;
        end
    end

    regfile_scoreboard u_scoreboard (
        .clk     (clk),
        .reset   (reset),
        .set_en  (b_issue_valid),
        .set_idx (b_issue_rd),
        .clr_en  (b_ready),
        .clr_idx (b_rd),
        .busy    (busy_mask)
    );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: a table of single-cycle
// vectors followed by hand-written multi-cycle sequences (contention,
// back-to-back writes, reset mid-stream). A small register-file model
// latches the write port on the falling edge.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_valid, b_valid, b_issue_valid;
    logic [4:0]  a_rd, b_rd, b_issue_rd;
    logic [63:0] a_data, b_data;
    logic        a_ready, b_ready;
    logic        RegWrite;
    logic [4:0]  RD;
    logic [63:0] WriteData;
    logic [31:0] busy_mask;

    logic [63:0] rf [32];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [63:0] ad;
        logic        bv;
        logic [4:0]  brd;
        logic [63:0] bd;
        logic        iv;
        logic [4:0]  ird;
        logic        ear;
        logic        ebr;
        logic        erw;
        logic [4:0]  erd;
        logic [63:0] ewd;
        logic [31:0] ebusy;
    } vec_t;

    vec_t vecs[12];

    regfile_wb_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .a_valid       (a_valid),
        .a_rd          (a_rd),
        .a_data        (a_data),
        .a_ready       (a_ready),
        .b_valid       (b_valid),
        .b_rd          (b_rd),
        .b_data        (b_data),
        .b_ready       (b_ready),
        .b_issue_valid (b_issue_valid),
        .b_issue_rd    (b_issue_rd),
        .RegWrite      (RegWrite),
        .RD            (RD),
        .WriteData     (WriteData),
        .busy_mask     (busy_mask)
    );

    always #5 clk = ~clk;

    // Register file model: writes land on the falling edge.
    always @(negedge clk) begin
        if (RegWrite && (RD != 5'd0)) begin
            rf[RD] <= WriteData;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        a_valid = 1'b0; a_rd = 5'd0; a_data = 64'h0;
        b_valid = 1'b0; b_rd = 5'd0; b_data = 64'h0;
        b_issue_valid = 1'b0; b_issue_rd = 5'd0;
    endtask

    initial begin
        for (int r = 0; r < 32; r++) rf[r] = 64'h0;
        idle_inputs();
        reset = 1'b1;

        //          av   ard   ad      bv   brd   bd      iv   ird   ear  ebr  erw  erd   ewd     ebusy
        vecs[0]  = '{1'b1,5'd5,64'h11, 1'b0,5'd0,64'h0,  1'b0,5'd0, 1'b1,1'b0,1'b1,5'd5,64'h11, 32'h0};
        vecs[1]  = '{1'b0,5'd0,64'h0,  1'b0,5'd0,64'h0,  1'b0,5'd0, 1'b0,1'b0,1'b0,5'd5,64'h11, 32'h0};
        vecs[2]  = '{1'b1,5'd0,64'hFF, 1'b0,5'd0,64'h0,  1'b0,5'd0, 1'b1,1'b0,1'b0,5'd5,64'h11, 32'h0};
        vecs[3]  = '{1'b0,5'd0,64'h0,  1'b0,5'd0,64'h0,  1'b1,5'd7, 1'b0,1'b0,1'b0,5'd5,64'h11, 32'h80};
        vecs[4]  = '{1'b0,5'd0,64'h0,  1'b1,5'd7,64'h77, 1'b0,5'd0, 1'b0,1'b1,1'b1,5'd7,64'h77, 32'h0};
        vecs[5]  = '{1'b0,5'd0,64'h0,  1'b1,5'd7,64'h78, 1'b1,5'd7, 1'b0,1'b1,1'b1,5'd7,64'h78, 32'h80};
        vecs[6]  = '{1'b0,5'd0,64'h0,  1'b1,5'd7,64'h79, 1'b0,5'd0, 1'b0,1'b1,1'b1,5'd7,64'h79, 32'h0};
        vecs[7]  = '{1'b0,5'd0,64'h0,  1'b0,5'd0,64'h0,  1'b1,5'd0, 1'b0,1'b0,1'b0,5'd7,64'h79, 32'h0};
        vecs[8]  = '{1'b1,5'd3,64'h33, 1'b0,5'd0,64'h0,  1'b1,5'd3, 1'b1,1'b0,1'b1,5'd3,64'h33, 32'h8};
        vecs[9]  = '{1'b1,5'd3,64'h34, 1'b0,5'd0,64'h0,  1'b0,5'd0, 1'b1,1'b0,1'b1,5'd3,64'h34, 32'h8};
        vecs[10] = '{1'b0,5'd0,64'h0,  1'b1,5'd0,64'hAB, 1'b0,5'd0, 1'b0,1'b1,1'b0,5'd3,64'h34, 32'h8};
        vecs[11] = '{1'b0,5'd0,64'h0,  1'b1,5'd3,64'h3B, 1'b0,5'd0, 1'b0,1'b1,1'b1,5'd3,64'h3B, 32'h0};

        // Reset: readies low even with requests present, then all state zero.
        repeat (2) @(posedge clk);
        #1;
        a_valid = 1'b1; a_rd = 5'd2; b_valid = 1'b1; b_rd = 5'd3;
        #1;
        chk("reset a_ready", 64'(a_ready), 64'h0);
        chk("reset b_ready", 64'(b_ready), 64'h0);
        @(posedge clk); #1;
        chk("reset RegWrite", 64'(RegWrite), 64'h0);
        chk("reset RD", 64'(RD), 64'h0);
        chk("reset WriteData", WriteData, 64'h0);
        chk("reset busy_mask", 64'(busy_mask), 64'h0);
        reset = 1'b0;
        idle_inputs();

        // Table-driven single-cycle vectors.
        for (int i = 0; i < 12; i++) begin
            a_valid = vecs[i].av;  a_rd = vecs[i].ard; a_data = vecs[i].ad;
            b_valid = vecs[i].bv;  b_rd = vecs[i].brd; b_data = vecs[i].bd;
            b_issue_valid = vecs[i].iv; b_issue_rd = vecs[i].ird;
            #1;
            chk($sformatf("vec%0d a_ready", i), 64'(a_ready), 64'(vecs[i].ear));
            chk($sformatf("vec%0d b_ready", i), 64'(b_ready), 64'(vecs[i].ebr));
            @(posedge clk); #1;
            chk($sformatf("vec%0d RegWrite", i), 64'(RegWrite), 64'(vecs[i].erw));
            chk($sformatf("vec%0d RD", i), 64'(RD), 64'(vecs[i].erd));
            chk($sformatf("vec%0d WriteData", i), WriteData, vecs[i].ewd);
            chk($sformatf("vec%0d busy_mask", i), 64'(busy_mask), 64'(vecs[i].ebusy));
        end
        idle_inputs();
        @(negedge clk); #1;
        chk("rf x5", rf[5], 64'h11);
        chk("rf x7", rf[7], 64'h79);
        chk("rf x3", rf[3], 64'h3B);
        chk("rf x0", rf[0], 64'h0);
        @(posedge clk); #1;

        // Contention: A wins 4 cycles, B the 5th, counter restarts from 0.
        for (int k = 0; k < 10; k++) begin
            logic eb;
            logic [4:0] erd;
            eb = (k == 4) || (k == 9);
            a_valid = 1'b1; a_rd = 5'(10 + k); a_data = 64'(32'h200 + k);
            b_valid = 1'b1;
            b_rd   = (k <= 4) ? 5'd9 : 5'd31;
            b_data = (k <= 4) ? 64'h99 : 64'hBB;
            erd = eb ? b_rd : a_rd;
            #1;
            chk($sformatf("cont%0d a_ready", k), 64'(a_ready), 64'(!eb));
            chk($sformatf("cont%0d b_ready", k), 64'(b_ready), 64'(eb));
            @(posedge clk); #1;
            chk($sformatf("cont%0d RegWrite", k), 64'(RegWrite), 64'h1);
            chk($sformatf("cont%0d RD", k), 64'(RD), 64'(erd));
        end
        idle_inputs();
        @(posedge clk); #1;
        chk("rf x9", rf[9], 64'h99);
        chk("rf x31", rf[31], 64'hBB);
        chk("rf x13", rf[13], 64'h203);

        // Back-to-back A writes to x1..x4.
        for (int i = 1; i <= 4; i++) begin
            a_valid = 1'b1; a_rd = 5'(i); a_data = 64'(32'h100 + i);
            #1;
            chk($sformatf("b2b%0d a_ready", i), 64'(a_ready), 64'h1);
            @(posedge clk); #1;
            chk($sformatf("b2b%0d RegWrite", i), 64'(RegWrite), 64'h1);
            chk($sformatf("b2b%0d RD", i), 64'(RD), 64'(i));
            chk($sformatf("b2b%0d WriteData", i), WriteData, 64'(32'h100 + i));
        end
        idle_inputs();
        @(posedge clk); #1;
        chk("b2b idle RegWrite", 64'(RegWrite), 64'h0);
        chk("rf x1", rf[1], 64'h101);
        chk("rf x4", rf[4], 64'h104);

        // Reset mid-stream with a busy bit set and the starve counter at 2.
        a_valid = 1'b1; a_rd = 5'd20; a_data = 64'h20;
        b_valid = 1'b1; b_rd = 5'd13; b_data = 64'h13;
        b_issue_valid = 1'b1; b_issue_rd = 5'd12;
        @(posedge clk); #1;
        chk("mid busy_mask", 64'(busy_mask), 64'h1000);
        b_issue_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        b_issue_valid = 1'b1;
        #1;
        chk("mid reset a_ready", 64'(a_ready), 64'h0);
        chk("mid reset b_ready", 64'(b_ready), 64'h0);
        @(posedge clk); #1;
        chk("mid reset RegWrite", 64'(RegWrite), 64'h0);
        chk("mid reset RD", 64'(RD), 64'h0);
        chk("mid reset WriteData", WriteData, 64'h0);
        chk("mid reset busy_mask", 64'(busy_mask), 64'h0);
        reset = 1'b0;
        b_issue_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("post%0d b_ready", k), 64'(b_ready), 64'(k == 4));
            chk($sformatf("post%0d a_ready", k), 64'(a_ready), 64'(k != 4));
            @(posedge clk); #1;
        end
        idle_inputs();
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
